// File: rtl/regfile_mp.sv
// Multi-read-port register file for the decode stage. It has a hardwired zero register,
// optional write-to-read bypass, a per-register pending scoreboard and a sequenced post-reset clear.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_pending,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_addr,
    output logic                  dbg_state_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // One extra counter bit keeps the terminal count distinct from entry 0.
    localparam logic [AW:0] CLR_LAST = (AW+1)'(NREGS - 1);

    state_t            state_q, state_d;
    logic [AW:0]       clr_cnt_q, clr_cnt_d;
    logic [AW-1:0]     clr_idx;
    logic              run;
    logic              we_eff;
    logic              iss_eff;
    logic [NREGS-1:0]  pending_q, pending_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        run         = (state_q == ST_RUN);
        init_done   = run;
        dbg_state_o = state_q;
    end

    assign clr_idx = clr_cnt_q[AW-1:0];
    assign we_eff  = run && we && !((ZERO_REG != 0) && (wa == '0));
    assign iss_eff = run && issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));

    // Storage has no reset; the clear sequence defines its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_idx] <= '0;
            end else if (we_eff) begin
                mem_q[wa] <= wd;
            end
        end
    end

    // Issue is applied after writeback so a new producer supersedes the retiring one.
    always_comb begin
        pending_d = pending_q;
        if (we_eff) begin
            pending_d[wa] = 1'b0;
        end
        if (iss_eff) begin
            pending_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // ---------------- read ports ----------------
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit_zero;
        logic          hit_wr;
        logic          hit_iss;

        assign addr     = rd_addr[g*AW +: AW];
        assign hit_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit_wr   = (BYPASS != 0) && we_eff && (wa == addr);
        assign hit_iss  = iss_eff && (issue_addr == addr);

        assign rd_data[g*XLEN +: XLEN] = (!run || hit_zero) ? '0 :
                                         hit_wr             ? wd :
                                                              mem_q[addr];

        // A same-cycle issue keeps the pre-edge pending view even when data is forwarded.
        assign rd_pending[g] = (!run || hit_zero)    ? 1'b0 :
                               (hit_wr && !hit_iss)  ? 1'b0 :
                                                       pending_q[addr];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default bypass build, a BYPASS=0 build sharing its inputs,
// and a 64-bit, 16-entry, 3-port build.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_v;
    logic [4:0]  iss_a;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        init_done;
    logic        dbg;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_pend;
    logic        nb_init_done;
    logic        nb_dbg;

    logic         p_rst;
    logic         p_we;
    logic [3:0]   p_wa;
    logic [63:0]  p_wd;
    logic         p_iv;
    logic [3:0]   p_ia;
    logic [11:0]  p_ra;
    logic [191:0] p_rd;
    logic [2:0]   p_rp;
    logic         p_done;
    logic         p_dbg;

    int checks   = 0;
    int failures = 0;
    int n;
    int nz;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pend),
        .we(we), .wa(wa), .wd(wd),
        .issue_valid(iss_v), .issue_addr(iss_a), .dbg_state_o(dbg)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .init_done(nb_init_done),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_pending(nb_rd_pend),
        .we(we), .wa(wa), .wd(wd),
        .issue_valid(iss_v), .issue_addr(iss_a), .dbg_state_o(nb_dbg)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3)) u_p (
        .clk(clk), .rst(p_rst), .init_done(p_done),
        .rd_addr(p_ra), .rd_data(p_rd), .rd_pending(p_rp),
        .we(p_we), .wa(p_wa), .wd(p_wd),
        .issue_valid(p_iv), .issue_addr(p_ia), .dbg_state_o(p_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts cycles with init_done low, starting in the first cycle after release.
    task automatic count_low(input int which, output int cnt);
        cnt = 0;
        while (cnt < 100 && !((which == 0) ? init_done : p_done)) begin
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_a = '0; rd_addr = '0;
        p_rst = 1'b1; p_we = 1'b0; p_wa = '0; p_wd = '0; p_iv = 1'b0; p_ia = '0; p_ra = '0;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_pend", 64'(rd_pend), 64'd0);
        chk("rst_state", 64'(dbg), 64'd0);

        // Clear with a stray write and issue that must be ignored
        @(negedge clk);
        rst = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF; iss_v = 1'b1; iss_a = 5'd4;
        rd_addr = {5'd4, 5'd3};
        #1;
        chk("clr_rd_data", rd_data, 64'd0);
        chk("clr_rd_pend", 64'(rd_pend), 64'd0);
        count_low(0, n);
        we = 1'b0; iss_v = 1'b0;
        chk("clr_len", 64'(n), 64'd32);
        chk("nb_init_done", 64'(nb_init_done), 64'd1);
        chk("run_state", 64'(dbg), 64'd1);
        #1;
        chk("clr_we_ignored", 64'(rd_data[31:0]), 64'd0);
        chk("clr_iss_ignored", 64'(rd_pend[1]), 64'd0);
        nz = 0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            if (rd_data !== 64'd0 || nb_rd_data !== 64'd0) nz++;
        end
        chk("clr_sweep_nonzero", 64'(nz), 64'd0);

        // Write then read, and writes to the zero register
        @(negedge clk); we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; rd_addr = {5'd6, 5'd6};
        @(negedge clk); we = 1'b0; rd_addr = {5'd5, 5'd5}; #1;
        chk("wr_rd_p0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("wr_rd_p1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
        chk("wr_rd_nb_p0", 64'(nb_rd_data[31:0]), 64'hDEAD_BEEF);
        @(negedge clk); we = 1'b1; wa = 5'd0; wd = 32'h1234_5678; rd_addr = {5'd5, 5'd0}; #1;
        chk("zero_byp", 64'(rd_data[31:0]), 64'd0);
        @(negedge clk); we = 1'b0; #1;
        chk("zero_rd", 64'(rd_data[31:0]), 64'd0);
        chk("zero_rd_nb", 64'(nb_rd_data[31:0]), 64'd0);

        // Bypass against a non-bypass build
        @(negedge clk); we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; rd_addr = {5'd5, 5'd7}; #1;
        chk("byp_data", 64'(rd_data[31:0]), 64'hA5A5_A5A5);
        chk("nobyp_old", 64'(nb_rd_data[31:0]), 64'd0);
        chk("byp_other_port", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
        @(negedge clk); we = 1'b0; #1;
        chk("nobyp_new", 64'(nb_rd_data[31:0]), 64'hA5A5_A5A5);

        // Scoreboard: issue, writeback, collision
        @(negedge clk); iss_v = 1'b1; iss_a = 5'd9; rd_addr = {5'd7, 5'd9}; #1;
        chk("iss_same_cycle", 64'(rd_pend[0]), 64'd0);
        @(negedge clk); iss_v = 1'b0; #1;
        chk("iss_pend", 64'(rd_pend[0]), 64'd1);
        chk("iss_pend_nb", 64'(nb_rd_pend[0]), 64'd1);
        chk("iss_other_port", 64'(rd_pend[1]), 64'd0);
        @(negedge clk); we = 1'b1; wa = 5'd9; wd = 32'h1111_1111; #1;
        chk("wb_byp_pend", 64'(rd_pend[0]), 64'd0);
        chk("wb_byp_data", 64'(rd_data[31:0]), 64'h1111_1111);
        chk("wb_nb_pend", 64'(nb_rd_pend[0]), 64'd1);
        @(negedge clk); we = 1'b0; #1;
        chk("wb_pend_clr", 64'(rd_pend[0]), 64'd0);
        chk("wb_pend_clr_nb", 64'(nb_rd_pend[0]), 64'd0);
        @(negedge clk); iss_v = 1'b1; iss_a = 5'd9;
        @(negedge clk); we = 1'b1; wa = 5'd9; wd = 32'h2222_2222; #1;
        chk("coll_byp_pend", 64'(rd_pend[0]), 64'd1);
        chk("coll_byp_data", 64'(rd_data[31:0]), 64'h2222_2222);
        @(negedge clk); we = 1'b0; iss_v = 1'b0; #1;
        chk("coll_pend", 64'(rd_pend[0]), 64'd1);
        chk("coll_pend_nb", 64'(nb_rd_pend[0]), 64'd1);
        chk("coll_data_nb", 64'(nb_rd_data[31:0]), 64'h2222_2222);
        @(negedge clk); iss_v = 1'b1; iss_a = 5'd0; rd_addr = {5'd9, 5'd0};
        @(negedge clk); iss_v = 1'b0; #1;
        chk("zero_never_pend", 64'(rd_pend[0]), 64'd0);
        chk("pend9_port1", 64'(rd_pend[1]), 64'd1);

        // Reset mid-run, then reset mid-clear
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_run_pend", 64'(rd_pend), 64'd0);
        chk("rst_run_pend_nb", 64'(nb_rd_pend), 64'd0);
        chk("rst_run_done", 64'(init_done), 64'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        count_low(0, n);
        chk("clr_restart_len", 64'(n), 64'd32);
        rd_addr = {5'd7, 5'd9}; #1;
        chk("after_rst_pend9", 64'(rd_pend[0]), 64'd0);
        chk("after_rst_data7", 64'(rd_data[63:32]), 64'd0);

        // Wide, shallow, three-port build
        @(negedge clk); p_rst = 1'b0; #1;
        count_low(1, n);
        chk("p_clr_len", 64'(n), 64'd16);
        @(negedge clk); p_we = 1'b1; p_wa = 4'd1;  p_wd = 64'h0123_4567_89AB_CDEF;
        @(negedge clk); p_we = 1'b1; p_wa = 4'd2;  p_wd = 64'hFEDC_BA98_7654_3210;
        @(negedge clk); p_we = 1'b1; p_wa = 4'd15; p_wd = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk); p_we = 1'b0; p_ra = {4'd15, 4'd2, 4'd1}; #1;
        chk("p_port0", p_rd[63:0], 64'h0123_4567_89AB_CDEF);
        chk("p_port1", p_rd[127:64], 64'hFEDC_BA98_7654_3210);
        chk("p_port2", p_rd[191:128], 64'hDEAD_BEEF_CAFE_F00D);
        chk("p_pend", 64'(p_rp), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file, successor to the core's fixed 32x32 two-read register file. Adds:
- configurable width, depth and read-port count
- hardwired zero register
- optional write-to-read bypass
- per-register pending scoreboard for pipeline hazard detection
- sequenced post-reset clear with a done flag

Sits in the decode stage. Read ports are fed by instruction source fields; the write port is fed by writeback; the issue port is driven by decode when an instruction with a destination is dispatched.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers (power of two, >=2)
AW, $clog2(NREGS), address width (derived, not overridden)
NREAD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
init_done  out  1  high once post-reset clear has completed
rd_addr  in  NREAD*AW  read addresses; port i = bits [i*AW +: AW]
rd_data  out  NREAD*XLEN  read data; port i = bits [i*XLEN +: XLEN]
rd_pending  out  NREAD  port i address has an outstanding write
we  in  1  write enable
wa  in  AW  write address
wd  in  XLEN  write data
issue_valid  in  1  mark issue_addr pending
issue_addr  in  AW  destination register being issued

Behaviour:
- Reset and clear state machine, states CLEAR and RUN:
  - rst=1 at an edge: state<=CLEAR, clr_cnt<=0, all pending bits<=0, init_done<=0. Applies from any state, including mid-clear, which restarts at 0.
  - CLEAR: each cycle writes 0 to mem[clr_cnt], clr_cnt<=clr_cnt+1.
  - CLEAR exit: after writing entry NREGS-1, next state is RUN and init_done<=1. Clear takes exactly NREGS cycles after rst deasserts; init_done rises on cycle NREGS.
  - In CLEAR, we and issue_valid are ignored, rd_data=0 and rd_pending=0 on all ports.
- RUN, writes:
  - we=1 at an edge: mem[wa]<=wd, and pending[wa]<=0.
  - ZERO_REG=1 and wa=0: the write is dropped.
- RUN, issue:
  - issue_valid=1 at an edge: pending[issue_addr]<=1.
  - Same-edge we=1 with wa==issue_addr: issue wins and the bit ends at 1, because the new producer supersedes the old one. The data is still written.
  - ZERO_REG=1 and issue_addr=0: ignored.
- Reads are combinational, zero latency:
  - rd_data[i] = mem[rd_addr[i]].
  - ZERO_REG=1 and rd_addr[i]=0: rd_data[i]=0 and rd_pending[i]=0.
  - BYPASS=1, we=1, wa==rd_addr[i] (and not the zero reg): rd_data[i]=wd and rd_pending[i]=0 in that same cycle, unless issue_valid with issue_addr==rd_addr[i] is also asserted. In that case rd_pending[i]=pending[rd_addr[i]] (pre-edge value) and rd_data[i] is still bypassed.
  - BYPASS=0: reads return the pre-edge contents and rd_pending[i]=pending[rd_addr[i]].
  - Multiple ports with the same address return identical values.
- Reset values: init_done=0; rd_data=0; rd_pending=0.
- Memory contents are undefined before the first clear completes. No initial blocks are relied on.
- All address arithmetic is modulo NREGS. clr_cnt is AW+1 bits wide so the terminal count is unambiguous.

Test Plan:
1. Clear sequencing: rst=1 for 2 cycles then 0 with defaults → init_done low for exactly 32 cycles and high on cycle 32; all 32 registers read 0 via port 0 sweep; we=1 during clear is ignored.
2. Write then read: write wa=5 wd=0xDEADBEEF, next cycle rd_addr0=5, rd_addr1=5 → both ports 0xDEADBEEF. Then write wa=0 wd=0x12345678 → port reading addr 0 returns 0.
3. Bypass: BYPASS=1, same cycle we=1 wa=7 wd=0xA5A5A5A5 and rd_addr0=7 → rd_data0=0xA5A5A5A5 combinationally. BYPASS=0 build → old value, then the new value one cycle later.
4. Scoreboard: issue_valid addr=9 → next cycle rd_pending for addr 9 =1. Writeback wa=9 → pending clears after the edge (0 same-cycle if BYPASS=1). Simultaneous issue and write on 9 → pending remains 1.
5. Reset mid-clear and mid-run: assert rst at clear cycle 10 → clear restarts and init_done rises 32 cycles after release. Assert rst with pending bits set → all rd_pending=0 after reset.
6. Parameter sweep: XLEN=64, NREGS=16, NREAD=3 → clear takes 16 cycles; three ports read independent addresses 1, 2 and 15 correctly with 64-bit data.
